down_counter_timer: RTL and testbench
=====================================

# down_counter_timer

Loadable, cascadable down-counter with a run/idle controller. It is the counting-down counterpart of the team's up-counter with carry-out. It gates decrements with a count enable, produces a combinational borrow-out for chaining the next stage, and either reloads automatically or stops at terminal count. It sits beside the datapath counters as the interval/timeout timer and as the reader-side element that drains a count produced by an up-counter.

## Interface
Parameters
- WIDTH, 8: counter and reload width in bits; legal range 2–16.

Ports
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low. Low clears all state immediately, independent of clk.
- load_in  input  WIDTH  value for count and reload register.
- load  input  1  synchronous load: count <= load_in, reload_reg <= load_in.
- start  input  1  synchronous; IDLE -> RUN. Ignored in RUN.
- stop  input  1  synchronous; RUN -> IDLE with count held. Ignored in IDLE.
- enable  input  1  decrement enable (borrow-in from the previous stage); only acts in RUN.
- auto_reload  input  1  terminal-count policy, sampled on the terminal cycle: 1 = reload and keep running, 0 = one-shot.
- count  output  WIDTH  current count value.
- b_out  output  1  combinational borrow: (state==RUN) && enable && (count==0) && !load && !stop.
- busy  output  1  high while state==RUN (registered state decode).
- done  output  1  registered one-cycle pulse after every terminal event.

## Operation
- States: IDLE (reset state) and RUN. busy = (state==RUN).
- Reset (reset low): state=IDLE, count=0, reload_reg=0, done=0. busy=0. b_out=0.
- Per-edge priority, highest first: load, stop, start, count.
  - load, any state: count and reload_reg take load_in. State is unchanged. No decrement and no terminal event that cycle.
  - stop in RUN: state=IDLE, count held, no decrement.
  - start in IDLE: state=RUN. count is not modified on the start cycle.
  - RUN, enable=1, count!=0: count <= count-1.
  - RUN, enable=1, count==0 (terminal event, b_out=1):
    - auto_reload=1: count <= reload_reg, remain RUN.
    - auto_reload=0: count stays 0, state=IDLE.
    - In both cases done=1 on the next cycle.
  - RUN, enable=0: count held.
- Arithmetic: decrement is modulo 2^WIDTH but never wraps. The zero case is always handled as a terminal event.
- Period in auto-reload with enable held high: reload_reg+1 enabled cycles between done pulses.
- Start with count==0 and enable=1: a terminal event occurs on the first RUN cycle.
- Cascading: b_out of stage N drives enable of stage N+1. Both stages share start/stop/load.

## Timing
- load, start, stop and decrement take effect at the next rising edge. count, busy and state change one cycle after the request.
- b_out is purely combinational from the current state, count and inputs, with zero-cycle latency. It is never high in IDLE.
- done is high for exactly one cycle, the cycle after the terminal edge. Back-to-back terminal events with reload_reg=0 and enable=1 produce done high on consecutive cycles.
- reset asserted mid-RUN: outputs return to their reset values immediately, asynchronously. A pending done pulse is cancelled.
- reset deassertion is synchronized externally. The first active edge after release obeys normal priority.
- Simultaneous events:
  - load+start in IDLE: load and start both apply; RUN begins with count=load_in.
  - load+stop in RUN: load applies, stop is ignored.
  - stop+terminal: stop wins; no reload and no done.

## Test plan
- Reset then load_in=8'h05, load, start, enable=1 continuously, auto_reload=0 -> count 5,4,3,2,1,0. b_out=1 for exactly one cycle at count 0. Next cycle: done=1, busy=0, count holds 0.
- Load 8'h02, auto_reload=1, start, enable=1 for 10 cycles -> count 2,1,0,2,1,0,… with done pulsing every 3 cycles and busy staying 1.
- Load 8'h04, start, enable toggled 1,0,1,0 -> count decrements only on enable-high edges (4,3,3,2,2). b_out stays 0.
- Load 8'h03 and run to count 1, then pulse stop -> busy=0 and count holds 1. A further start resumes to 0 with done pulse.
- Two instances cascaded (low b_out -> high enable), both loaded 8'h01, auto_reload=1 -> the high stage decrements once per two low-stage terminal events. Borrow-out of the high stage is observed at combined terminal count.
- Assert reset low mid-RUN at count 8'h07 between clock edges -> count=0, busy=0, done=0 immediately. No done pulse after release.

Source files
------------

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: load/run controls in,
// count value and status flags out.
interface down_counter_timer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_in;
  logic             load;
  logic             start;
  logic             stop;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             b_out;
  logic             busy;
  logic             done;

  modport master (
    output load_in, load, start, stop, enable, auto_reload,
    input  count, b_out, busy, done
  );

  modport slave (
    input  load_in, load, start, stop, enable, auto_reload,
    output count, b_out, busy, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable, cascadable down-counter with IDLE/RUN control, combinational
// borrow-out for chaining and a registered done pulse per terminal event.
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  down_counter_timer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_reg;
  logic             done_r;
  logic             terminal;

  // Zero is always a terminal event, so the decrement saturates instead of wrapping.
  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    if (v == '0) return v;
    return v - {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign terminal = (state == RUN) && bus.enable && (count_r == '0) &&
                    !bus.load && !bus.stop;

  assign bus.b_out = terminal;
  assign bus.busy  = (state == RUN);
  assign bus.count = count_r;
  assign bus.done  = done_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count_r    <= '0;
      reload_reg <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.load) begin
        // Load overrides stop and counting, but a start in IDLE still launches RUN.
        count_r    <= bus.load_in;
        reload_reg <= bus.load_in;
        if (state == IDLE && bus.start) state <= RUN;
      end else if (state == RUN && bus.stop) begin
        state <= IDLE;
      end else if (state == IDLE && bus.start) begin
        state <= RUN;
      end else if (state == RUN && bus.enable) begin
        if (terminal) begin
          done_r <= 1'b1;
          if (bus.auto_reload) count_r <= reload_reg;
          else                 state   <= IDLE;
        end else begin
          count_r <= dec_sat(count_r);
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: a driver queues the expected
// outputs for every cycle and an independent monitor compares them.
module tb_down_counter_timer;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;

  down_counter_timer_if #(.WIDTH(WIDTH)) lo_if ();
  down_counter_timer_if #(.WIDTH(WIDTH)) hi_if ();

  down_counter_timer #(.WIDTH(WIDTH)) u_lo (.clk(clk), .reset(reset), .bus(lo_if));
  down_counter_timer #(.WIDTH(WIDTH)) u_hi (.clk(clk), .reset(reset), .bus(hi_if));

  // High stage shares controls with the low stage; its enable is the low borrow.
  assign hi_if.load_in     = lo_if.load_in;
  assign hi_if.load        = lo_if.load;
  assign hi_if.start       = lo_if.start;
  assign hi_if.stop        = lo_if.stop;
  assign hi_if.auto_reload = lo_if.auto_reload;
  assign hi_if.enable      = lo_if.b_out;

  typedef struct {
    string      nm;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       b;
    logic       chk_hi;
    logic [7:0] hcnt;
    logic       hb;
    logic       hd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples 2 time units after each falling edge, once inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (lo_if.count !== e.cnt || lo_if.busy !== e.busy ||
            lo_if.done !== e.done || lo_if.b_out !== e.b ||
            (e.chk_hi && (hi_if.count !== e.hcnt || hi_if.b_out !== e.hb ||
                          hi_if.done !== e.hd))) begin
          $display("FAIL %s: got count=%0h busy=%0b done=%0b b_out=%0b hi_count=%0h hi_b_out=%0b hi_done=%0b, want count=%0h busy=%0b done=%0b b_out=%0b hi(check=%0b) count=%0h b_out=%0b done=%0b",
                   e.nm, lo_if.count, lo_if.busy, lo_if.done, lo_if.b_out,
                   hi_if.count, hi_if.b_out, hi_if.done,
                   e.cnt, e.busy, e.done, e.b, e.chk_hi, e.hcnt, e.hb, e.hd);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the expected outputs.
  task automatic cyh(input logic rst_v, input logic ld, input logic st,
                     input logic sp, input logic en, input logic ar,
                     input logic [7:0] li, input logic [7:0] ec,
                     input logic ebusy, input logic edone, input logic eb,
                     input logic chk, input logic [7:0] hc, input logic hb,
                     input logic hd, input string nm);
    exp_t e;
    @(negedge clk);
    reset             = rst_v;
    lo_if.load        = ld;
    lo_if.start       = st;
    lo_if.stop        = sp;
    lo_if.enable      = en;
    lo_if.auto_reload = ar;
    lo_if.load_in     = li;
    e.nm = nm; e.cnt = ec; e.busy = ebusy; e.done = edone; e.b = eb;
    e.chk_hi = chk; e.hcnt = hc; e.hb = hb; e.hd = hd;
    q.push_back(e);
  endtask

  task automatic cy(input logic ld, input logic st, input logic sp,
                    input logic en, input logic ar, input logic [7:0] li,
                    input logic [7:0] ec, input logic ebusy, input logic edone,
                    input logic eb, input string nm);
    cyh(1'b1, ld, st, sp, en, ar, li, ec, ebusy, edone, eb,
        1'b0, 8'h00, 1'b0, 1'b0, nm);
  endtask

  initial begin
    int guard;
    reset             = 1'b0;
    lo_if.load        = 1'b0;
    lo_if.start       = 1'b0;
    lo_if.stop        = 1'b0;
    lo_if.enable      = 1'b0;
    lo_if.auto_reload = 1'b0;
    lo_if.load_in     = 8'h00;

    // reset state, then one-shot count from 5
    cyh(1'b0, 0,0,0,0,0, 8'h00, 8'h00,0,0,0, 1'b1, 8'h00,0,0, "reset_state");
    cy(1,0,0,1,0, 8'h05, 8'h00,0,0,0, "os_load");
    cy(0,1,0,1,0, 8'h00, 8'h05,0,0,0, "os_start");
    cy(0,0,0,1,0, 8'h00, 8'h05,1,0,0, "os_c5");
    cy(0,0,0,1,0, 8'h00, 8'h04,1,0,0, "os_c4");
    cy(0,0,0,1,0, 8'h00, 8'h03,1,0,0, "os_c3");
    cy(0,0,0,1,0, 8'h00, 8'h02,1,0,0, "os_c2");
    cy(0,0,0,1,0, 8'h00, 8'h01,1,0,0, "os_c1");
    cy(0,0,0,1,0, 8'h00, 8'h00,1,0,1, "os_terminal");
    cy(0,0,0,1,0, 8'h00, 8'h00,0,1,0, "os_done");
    cy(0,0,0,1,0, 8'h00, 8'h00,0,0,0, "os_idle_hold");

    // auto-reload from 2: period of 3 enabled cycles
    cy(1,0,0,1,1, 8'h02, 8'h00,0,0,0, "ar_load");
    cy(0,1,0,1,1, 8'h00, 8'h02,0,0,0, "ar_start");
    cy(0,0,0,1,1, 8'h00, 8'h02,1,0,0, "ar_r1");
    cy(0,0,0,1,1, 8'h00, 8'h01,1,0,0, "ar_r2");
    cy(0,0,0,1,1, 8'h00, 8'h00,1,0,1, "ar_r3");
    cy(0,0,0,1,1, 8'h00, 8'h02,1,1,0, "ar_r4");
    cy(0,0,0,1,1, 8'h00, 8'h01,1,0,0, "ar_r5");
    cy(0,0,0,1,1, 8'h00, 8'h00,1,0,1, "ar_r6");
    cy(0,0,0,1,1, 8'h00, 8'h02,1,1,0, "ar_r7");
    cy(0,0,0,1,1, 8'h00, 8'h01,1,0,0, "ar_r8");
    cy(0,0,0,1,1, 8'h00, 8'h00,1,0,1, "ar_r9");
    cy(0,0,0,1,1, 8'h00, 8'h02,1,1,0, "ar_r10");
    cy(0,0,1,1,1, 8'h00, 8'h01,1,0,0, "ar_stop");
    cy(0,0,0,1,1, 8'h00, 8'h01,0,0,0, "ar_stopped");

    // load+start together, then enable toggling
    cy(1,1,0,0,0, 8'h04, 8'h01,0,0,0, "tg_load_start");
    cy(0,0,0,1,0, 8'h00, 8'h04,1,0,0, "tg_e1");
    cy(0,0,0,0,0, 8'h00, 8'h03,1,0,0, "tg_e0");
    cy(0,0,0,1,0, 8'h00, 8'h03,1,0,0, "tg_e1b");
    cy(0,0,0,0,0, 8'h00, 8'h02,1,0,0, "tg_e0b");
    cy(1,0,1,1,0, 8'h03, 8'h02,1,0,0, "load_stop");

    // run to 1, stop, resume to terminal
    cy(0,0,0,1,0, 8'h00, 8'h03,1,0,0, "sr_c3");
    cy(0,0,0,1,0, 8'h00, 8'h02,1,0,0, "sr_c2");
    cy(0,0,1,1,0, 8'h00, 8'h01,1,0,0, "sr_stop");
    cy(0,0,0,1,0, 8'h00, 8'h01,0,0,0, "sr_held");
    cy(0,1,0,1,0, 8'h00, 8'h01,0,0,0, "sr_restart");
    cy(0,0,0,1,0, 8'h00, 8'h01,1,0,0, "sr_c1");
    cy(0,0,0,1,0, 8'h00, 8'h00,1,0,1, "sr_terminal");
    cy(0,0,0,1,0, 8'h00, 8'h00,0,1,0, "sr_done");

    // stop beats terminal
    cy(1,1,0,0,1, 8'h00, 8'h00,0,0,0, "st_load0");
    cy(0,0,1,1,1, 8'h00, 8'h00,1,0,0, "st_stop_term");
    cy(0,0,0,1,1, 8'h00, 8'h00,0,0,0, "st_no_done");

    // reload value 0: back-to-back terminal events
    cy(0,1,0,1,1, 8'h00, 8'h00,0,0,0, "bb_start");
    cy(0,0,0,1,1, 8'h00, 8'h00,1,0,1, "bb_t1");
    cy(0,0,0,1,1, 8'h00, 8'h00,1,1,1, "bb_t2");
    cy(0,0,0,1,1, 8'h00, 8'h00,1,1,1, "bb_t3");
    cy(0,0,0,0,1, 8'h00, 8'h00,1,1,0, "bb_en0");
    cy(0,0,0,0,1, 8'h00, 8'h00,1,0,0, "bb_quiet");
    cy(0,0,1,0,1, 8'h00, 8'h00,1,0,0, "bb_stop");

    // cascade: both stages loaded with 1, auto-reload
    cy(0,0,1,0,1, 8'h00, 8'h00,0,0,0, "cs_stop");
    cy(1,1,0,0,1, 8'h01, 8'h00,0,0,0, "cs_load_start");
    cyh(1, 0,0,0,1,1, 8'h00, 8'h01,1,0,0, 1, 8'h01,0,0, "cs_k2");
    cyh(1, 0,0,0,1,1, 8'h00, 8'h00,1,0,1, 1, 8'h01,0,0, "cs_k3");
    cyh(1, 0,0,0,1,1, 8'h00, 8'h01,1,1,0, 1, 8'h00,0,0, "cs_k4");
    cyh(1, 0,0,0,1,1, 8'h00, 8'h00,1,0,1, 1, 8'h00,1,0, "cs_k5_hi_borrow");
    cyh(1, 0,0,0,1,1, 8'h00, 8'h01,1,1,0, 1, 8'h01,0,1, "cs_k6");
    cyh(1, 0,0,0,1,1, 8'h00, 8'h00,1,0,1, 1, 8'h01,0,0, "cs_k7");
    cyh(1, 0,0,1,1,1, 8'h00, 8'h01,1,1,0, 1, 8'h00,0,0, "cs_stop2");

    // asynchronous reset mid-RUN at count 7
    cy(1,1,0,0,0, 8'h07, 8'h01,0,0,0, "rs_load_start");
    cy(0,0,0,0,0, 8'h00, 8'h07,1,0,0, "rs_run7");
    cyh(0, 0,0,0,0,0, 8'h00, 8'h00,0,0,0, 1, 8'h00,0,0, "rs_async_clear");
    cyh(0, 0,1,0,1,0, 8'h00, 8'h00,0,0,0, 1, 8'h00,0,0, "rs_held_low");
    cy(0,0,0,1,0, 8'h00, 8'h00,0,0,0, "rs_release");
    cy(0,0,0,1,0, 8'h00, 8'h00,0,0,0, "rs_no_done");

    // start with count 0 and enable high: terminal on first RUN cycle
    cy(0,1,0,1,0, 8'h00, 8'h00,0,0,0, "z_start");
    cy(0,0,0,1,0, 8'h00, 8'h00,1,0,1, "z_terminal");
    cy(0,0,0,0,0, 8'h00, 8'h00,0,1,0, "z_done");

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
